// File: rtl/vram_write_scheduler.sv
// Write-port scheduler for the 32x32 video memory: arbitrates a buffered CPU
// write stream against a rectangle-fill engine, optionally only during blanking.
module vram_write_scheduler #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int BLANK_ONLY = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuWrite,
  input  logic [ADDR_WIDTH-1:0] iCpuAddr,
  input  logic [DATA_WIDTH-1:0] iCpuData,
  output logic                  oCpuFull,
  output logic                  oCpuDrop,
  input  logic                  iFillStart,
  input  logic [4:0]            iFillX0,
  input  logic [4:0]            iFillY0,
  input  logic [4:0]            iFillX1,
  input  logic [4:0]            iFillY1,
  input  logic [DATA_WIDTH-1:0] iFillColor,
  output logic                  oFillBusy,
  output logic                  oFillDone,
  input  logic                  iBlank,
  output logic                  oMemWrite,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemData
);

  // state  | meaning
  // IDLE   | no fill; waiting for iFillStart
  // FILL   | cursor walks the rectangle row by row, one cell per fill grant
  // DONE   | single cycle after the last cell; pulses oFillDone
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_e;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  drop_q, drop_d;

  fill_state_e           state_q, state_d;
  logic [4:0]            xmin_q, xmin_d, xmax_q, xmax_d;
  logic [4:0]            ymin_q, ymin_d, ymax_q, ymax_d;
  logic [4:0]            cx_q, cx_d, cy_q, cy_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  prio_fill_q, prio_fill_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic slot, cpu_req, fill_req, contested;
  logic grant_cpu, grant_fill, push, pop;
  logic [ADDR_WIDTH-1:0] fill_addr;

  assign fill_addr = ADDR_WIDTH'({cy_q, cx_q});

  // Arbitration: prio_fill_q names the side that wins the next contested slot.
  always_comb begin
    slot       = (BLANK_ONLY == 0) || iBlank;
    cpu_req    = (count_q != '0);
    fill_req   = (state_q == S_FILL);
    contested  = slot && cpu_req && fill_req;
    grant_cpu  = slot && cpu_req && (!fill_req || !prio_fill_q);
    grant_fill = slot && fill_req && (!cpu_req || prio_fill_q);
    push       = iCpuWrite && !full_q;
    pop        = grant_cpu;

    prio_fill_d = contested ? grant_cpu : prio_fill_q;

    mem_write_d = grant_cpu || grant_fill;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    if (grant_cpu) begin
      mem_addr_d = fifo_addr_q[rd_ptr_q];
      mem_data_d = fifo_data_q[rd_ptr_q];
    end else if (grant_fill) begin
      mem_addr_d = fill_addr;
      mem_data_d = color_q;
    end
  end

  // A push against a full FIFO is refused even when a pop frees a slot this cycle.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = iCpuAddr;
      fifo_data_d[wr_ptr_q] = iCpuData;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == DEPTH_C);
    drop_d   = iCpuWrite && full_q;
  end

  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    case (state_q)
      S_IDLE: begin
        if (iFillStart) begin
          xmin_d  = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
          xmax_d  = (iFillX0 < iFillX1) ? iFillX1 : iFillX0;
          ymin_d  = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
          ymax_d  = (iFillY0 < iFillY1) ? iFillY1 : iFillY0;
          cx_d    = xmin_d;
          cy_d    = ymin_d;
          color_d = iFillColor;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (grant_fill) begin
          if (cx_q != xmax_q) begin
            cx_d = cx_q + 5'd1;
          end else begin
            cx_d = xmin_q;
            // cy stays put on the last row so it never has to exceed 31
            if (cy_q == ymax_q) state_d = S_DONE;
            else                cy_d    = cy_q + 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FILL);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      drop_q      <= 1'b0;
      state_q     <= S_IDLE;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      color_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prio_fill_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prio_fill_q <= prio_fill_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign oCpuFull  = full_q;
  assign oCpuDrop  = drop_q;
  assign oFillBusy = busy_q;
  assign oFillDone = done_q;
  assign oMemWrite = mem_write_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemData  = mem_data_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: two instances (always-slot and blank-gated)
// share stimulus; a queue/cell-list reference model checks every cycle.
module tb_vram_write_scheduler;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [2:0] cpu_data = '0;
  logic       fill_start = 1'b0;
  logic [4:0] fx0 = '0, fy0 = '0, fx1 = '0, fy1 = '0;
  logic [2:0] fill_col = '0;
  logic       blank = 1'b0;

  logic [1:0] o_full, o_drop, o_busy, o_done, o_mw;
  logic [9:0] o_addr [2];
  logic [2:0] o_data [2];

  always #5 clk = ~clk;

  vram_write_scheduler #(.BLANK_ONLY(0)) dut_a (
    .Clock(clk), .Reset(rst_n),
    .iCpuWrite(cpu_wr), .iCpuAddr(cpu_addr), .iCpuData(cpu_data),
    .oCpuFull(o_full[0]), .oCpuDrop(o_drop[0]),
    .iFillStart(fill_start), .iFillX0(fx0), .iFillY0(fy0), .iFillX1(fx1), .iFillY1(fy1),
    .iFillColor(fill_col), .oFillBusy(o_busy[0]), .oFillDone(o_done[0]),
    .iBlank(blank), .oMemWrite(o_mw[0]), .oMemAddr(o_addr[0]), .oMemData(o_data[0]));

  vram_write_scheduler #(.BLANK_ONLY(1)) dut_b (
    .Clock(clk), .Reset(rst_n),
    .iCpuWrite(cpu_wr), .iCpuAddr(cpu_addr), .iCpuData(cpu_data),
    .oCpuFull(o_full[1]), .oCpuDrop(o_drop[1]),
    .iFillStart(fill_start), .iFillX0(fx0), .iFillY0(fy0), .iFillX1(fx1), .iFillY1(fy1),
    .iFillColor(fill_col), .oFillBusy(o_busy[1]), .oFillDone(o_done[1]),
    .iBlank(blank), .oMemWrite(o_mw[1]), .oMemAddr(o_addr[1]), .oMemData(o_data[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, one copy per instance
  logic [9:0] m_fa [2][D];
  logic [2:0] m_fd [2][D];
  int         m_head [2], m_cnt [2], m_phase [2], m_ncell [2], m_idx [2];
  logic [2:0] m_color [2];
  bit         m_lastcpu [2];
  logic [9:0] m_cells [2][1024];

  logic       e_mw [2], e_full [2], e_drop [2], e_busy [2], e_done [2];
  logic [9:0] e_addr [2];
  logic [2:0] e_data [2];

  int wlog_addr [$];
  int wlog_data [$];
  int done_cnt = 0;

  typedef struct {
    logic       wr;
    logic [9:0] addr;
    logic [2:0] data;
    logic       blank;
    logic       x_mw;
    logic [9:0] x_addr;
    logic [2:0] x_data;
    logic       x_full;
    logic       x_drop;
  } vec_t;
  vec_t tbl [12];

  task automatic model_edge();
    bit slot, creq, freq, gc, gf, push_ok;
    int xlo, xhi, ylo, yhi;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_head[k] = 0; m_cnt[k] = 0; m_phase[k] = 0; m_idx[k] = 0; m_ncell[k] = 0;
        m_lastcpu[k] = 1'b0;
        e_mw[k] = 0; e_full[k] = 0; e_drop[k] = 0; e_busy[k] = 0; e_done[k] = 0;
        e_addr[k] = '0; e_data[k] = '0;
      end else begin
        slot = (k == 0) || blank;
        creq = m_cnt[k] > 0;
        freq = m_phase[k] == 1;
        gc = 0; gf = 0;
        if (slot && creq && freq) begin
          if (m_lastcpu[k]) gf = 1; else gc = 1;
          m_lastcpu[k] = gc;
        end else if (slot) begin
          gc = creq; gf = freq;
        end
        e_drop[k] = cpu_wr && (m_cnt[k] == D);
        push_ok   = cpu_wr && (m_cnt[k] != D);
        e_mw[k]   = gc || gf;
        e_addr[k] = '0; e_data[k] = '0;
        if (gc) begin
          e_addr[k] = m_fa[k][m_head[k]];
          e_data[k] = m_fd[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % D;
          m_cnt[k]--;
        end
        if (gf) begin
          e_addr[k] = m_cells[k][m_idx[k]];
          e_data[k] = m_color[k];
        end
        if (push_ok) begin
          m_fa[k][(m_head[k] + m_cnt[k]) % D] = cpu_addr;
          m_fd[k][(m_head[k] + m_cnt[k]) % D] = cpu_data;
          m_cnt[k]++;
        end
        case (m_phase[k])
          2: m_phase[k] = 0;
          1: if (gf) begin
               m_idx[k]++;
               if (m_idx[k] == m_ncell[k]) m_phase[k] = 2;
             end
          default: if (fill_start) begin
               xlo = (fx0 < fx1) ? int'(fx0) : int'(fx1);
               xhi = (fx0 < fx1) ? int'(fx1) : int'(fx0);
               ylo = (fy0 < fy1) ? int'(fy0) : int'(fy1);
               yhi = (fy0 < fy1) ? int'(fy1) : int'(fy0);
               m_ncell[k] = 0;
               for (int y = ylo; y <= yhi; y++)
                 for (int x = xlo; x <= xhi; x++) begin
                   m_cells[k][m_ncell[k]] = 10'(y * 32 + x);
                   m_ncell[k]++;
                 end
               m_idx[k] = 0;
               m_color[k] = fill_col;
               m_phase[k] = 1;
             end
        endcase
        e_busy[k] = m_phase[k] == 1;
        e_done[k] = m_phase[k] == 2;
        e_full[k] = m_cnt[k] == D;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_mw[k] !== e_mw[k] || (e_mw[k] && (o_addr[k] !== e_addr[k] || o_data[k] !== e_data[k])) ||
          o_full[k] !== e_full[k] || o_drop[k] !== e_drop[k] || o_busy[k] !== e_busy[k] ||
          o_done[k] !== e_done[k]) begin
        errors++;
        $display("FAIL model dut%0d cycle %0d: got mw=%b addr=%h data=%0d full=%b drop=%b busy=%b done=%b, want mw=%b addr=%h data=%0d full=%b drop=%b busy=%b done=%b",
                 k, cyc, o_mw[k], o_addr[k], o_data[k], o_full[k], o_drop[k], o_busy[k], o_done[k],
                 e_mw[k], e_addr[k], e_data[k], e_full[k], e_drop[k], e_busy[k], e_done[k]);
      end
    end
    if (o_mw[0] === 1'b1) begin
      wlog_addr.push_back(int'(o_addr[0]));
      wlog_data.push_back(int'(o_data[0]));
    end
    if (o_done[0] === 1'b1) done_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
    cyc++;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
    done_cnt = 0;
  endtask

  task automatic set_fill(input int x0, input int y0, input int x1, input int y1, input int col);
    fx0 = 5'(x0); fy0 = 5'(y0); fx1 = 5'(x1); fy1 = 5'(y1); fill_col = 3'(col);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int seq_a [7];
    int seq_d [7];

    tbl[0]  = '{1'b1, 10'h100, 3'd1, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 10'h101, 3'd2, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 10'h102, 3'd3, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 10'h103, 3'd4, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 10'h104, 3'd5, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 10'h000, 3'd0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 10'h105, 3'd6, 1'b1, 1'b1, 10'h100, 3'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 10'h000, 3'd0, 1'b1, 1'b1, 10'h101, 3'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 10'h000, 3'd0, 1'b1, 1'b1, 10'h102, 3'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 10'h000, 3'd0, 1'b1, 1'b1, 10'h103, 3'd4, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 10'h000, 3'd0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 10'h000, 3'd0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    expect_int("reset_mw", int'(o_mw), 0);
    expect_int("reset_full", int'(o_full), 0);
    expect_int("reset_busy", int'(o_busy), 0);

    // CPU-only latency on the always-slot instance
    clear_log();
    cpu_wr = 1'b1; cpu_addr = 10'h021; cpu_data = 3'b101;
    step();
    cpu_wr = 1'b0;
    expect_int("cpu_lat_early_mw", int'(o_mw[0]), 0);
    step();
    expect_int("cpu_lat_mw", int'(o_mw[0]), 1);
    expect_int("cpu_lat_addr", int'(o_addr[0]), 'h021);
    expect_int("cpu_lat_data", int'(o_data[0]), 5);
    expect_int("cpu_lat_full", int'(o_full[0]), 0);
    blank = 1'b1;
    repeat (3) step();
    blank = 1'b0;

    // Overflow while gated, then drain in FIFO order (blank-gated instance)
    for (int i = 0; i < 12; i++) begin
      cpu_wr = tbl[i].wr; cpu_addr = tbl[i].addr; cpu_data = tbl[i].data; blank = tbl[i].blank;
      step();
      checks++;
      if (o_mw[1] !== tbl[i].x_mw ||
          (tbl[i].x_mw && (o_addr[1] !== tbl[i].x_addr || o_data[1] !== tbl[i].x_data)) ||
          o_full[1] !== tbl[i].x_full || o_drop[1] !== tbl[i].x_drop) begin
        errors++;
        $display("FAIL tbl[%0d]: got mw=%b addr=%h data=%0d full=%b drop=%b, want mw=%b addr=%h data=%0d full=%b drop=%b",
                 i, o_mw[1], o_addr[1], o_data[1], o_full[1], o_drop[1],
                 tbl[i].x_mw, tbl[i].x_addr, tbl[i].x_data, tbl[i].x_full, tbl[i].x_drop);
      end
    end
    cpu_wr = 1'b0;

    // Single-row fill with swapped X corners
    blank = 1'b1;
    clear_log();
    set_fill(3, 2, 1, 2, 2);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    expect_int("fill_busy_start", int'(o_busy[0]), 1);
    repeat (6) step();
    expect_int("fill_nwrites", wlog_addr.size(), 3);
    for (int i = 0; i < 3 && i < wlog_addr.size(); i++) begin
      expect_int($sformatf("fill_addr%0d", i), wlog_addr[i], 'h041 + i);
      expect_int($sformatf("fill_data%0d", i), wlog_data[i], 2);
    end
    expect_int("fill_done_pulses", done_cnt, 1);
    expect_int("fill_busy_after", int'(o_busy[0]), 0);

    // Contention: 2x2 fill against three CPU writes, alternating grants
    do_reset();
    clear_log();
    set_fill(0, 0, 1, 1, 1);
    fill_start = 1'b1;
    cpu_wr = 1'b1; cpu_addr = 10'h3FF; cpu_data = 3'd7;
    step();
    fill_start = 1'b0;
    cpu_addr = 10'h3FE; cpu_data = 3'd6;
    step();
    cpu_addr = 10'h3FD; cpu_data = 3'd5;
    step();
    cpu_wr = 1'b0;
    repeat (8) step();
    seq_a = '{'h3FF, 'h000, 'h3FE, 'h001, 'h3FD, 'h020, 'h021};
    seq_d = '{7, 1, 6, 1, 5, 1, 1};
    expect_int("cont_nwrites", wlog_addr.size(), 7);
    for (int i = 0; i < 7 && i < wlog_addr.size(); i++) begin
      expect_int($sformatf("cont_addr%0d", i), wlog_addr[i], seq_a[i]);
      expect_int($sformatf("cont_data%0d", i), wlog_data[i], seq_d[i]);
    end

    // iFillStart while busy or done is ignored
    clear_log();
    set_fill(1, 5, 0, 5, 3);
    fill_start = 1'b1;
    step();
    set_fill(9, 9, 12, 12, 6);
    repeat (3) step();
    fill_start = 1'b0;
    repeat (4) step();
    expect_int("restart_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() >= 2) begin
      expect_int("restart_addr0", wlog_addr[0], 'h0A0);
      expect_int("restart_addr1", wlog_addr[1], 'h0A1);
    end
    expect_int("restart_done", done_cnt, 1);

    // Reset mid-fill, with a CPU write queued just before
    clear_log();
    set_fill(4, 1, 6, 2, 4);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    step();
    cpu_wr = 1'b1; cpu_addr = 10'h155; cpu_data = 3'd3;
    step();
    cpu_wr = 1'b0;
    expect_int("midrst_pre_n", wlog_addr.size(), 2);
    do_reset();
    expect_int("midrst_mw", int'(o_mw), 0);
    expect_int("midrst_busy", int'(o_busy), 0);
    expect_int("midrst_full", int'(o_full), 0);
    clear_log();
    repeat (3) step();
    expect_int("midrst_flushed", wlog_addr.size(), 0);
    set_fill(2, 3, 2, 3, 5);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (4) step();
    expect_int("midrst_new_n", wlog_addr.size(), 1);
    if (wlog_addr.size() >= 1) expect_int("midrst_new_addr", wlog_addr[0], 'h062);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      blank      = $urandom_range(0, 1) == 1;
      cpu_wr     = $urandom_range(0, 1) == 1;
      cpu_addr   = 10'($urandom_range(0, 1023));
      cpu_data   = 3'($urandom_range(0, 7));
      fill_start = ($urandom_range(0, 19) == 0);
      fx0 = 5'($urandom_range(0, 31));
      fy0 = 5'($urandom_range(0, 31));
      fx1 = fx0 ^ 5'($urandom_range(0, 7));
      fy1 = fy0 ^ 5'($urandom_range(0, 3));
      fill_col = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
